// File: rtl/cpu_types_pkg.sv
// Shared types for the data-side memory responder: word type, FSM state,
// request kinds and the SC result encodings.
package cpu_types_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dresp_state_t;

    typedef enum logic [1:0] {
        RD = 2'd0,
        WR = 2'd1,
        LL = 2'd2,
        SC = 2'd3
    } req_kind_t;

    localparam word_t SC_SUCCESS = 32'd1;
    localparam word_t SC_FAIL    = 32'd0;

    // A request carrying both strobes is a write; datomic upgrades to LL/SC.
    function automatic req_kind_t decode_kind(input logic ren, input logic wen,
                                              input logic atomic);
        req_kind_t k;
        if (wen)
            k = atomic ? SC : WR;
        else if (ren)
            k = atomic ? LL : RD;
        else
            k = RD;
        return k;
    endfunction

endpackage

// File: rtl/atomic_link_reg.sv
// LL/SC link register: holds the reserved word address and reports
// whether a compare address or a snooped write hits the live reservation.
module atomic_link_reg #(
    parameter int AW = 30
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          set,
    input  logic [AW-1:0] set_addr,
    input  logic          clear,
    input  logic          halt,
    input  logic          snoop,
    input  logic [AW-1:0] snoop_addr,
    input  logic [AW-1:0] cmp_addr,
    output logic          match,
    output logic          snoop_hit
);

    logic          link_valid;
    logic [AW-1:0] link_addr;
    logic          snoop_hit_set;

    assign match         = link_valid && (link_addr == cmp_addr);
    assign snoop_hit     = snoop && link_valid && (link_addr == snoop_addr);
    assign snoop_hit_set = snoop && (set_addr == snoop_addr);

    // A snoop to the word being linked in the same cycle wins over the LL.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (set) begin
            link_valid <= !snoop_hit_set && !halt;
            link_addr  <= set_addr;
        end else if (clear || halt || snoop_hit) begin
            link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/atomic_dmem_responder.sv
// Memory-stage data responder: one word access per request, LL/SC link
// tracking and a single-cycle dhit completion pulse.
//
// state  | meaning
// IDLE   | waiting for dmemREN/dmemWEN; failed SC goes straight to DONE
// ACCESS | strobe held on the controller port until dwait drops
// DONE   | dhit high, dmemload valid; back to IDLE next cycle
module atomic_dmem_responder
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic              datomic,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    input  logic              halt,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    input  logic [WORD_W-1:0] dload,
    input  logic              dwait,
    input  logic              snoopvalid,
    input  logic [WORD_W-1:0] snoopaddr
);

    dresp_state_t      state, state_nxt;
    req_kind_t         req_kind, kind_q;
    logic [WORD_W-3:0] word_q;
    logic [WORD_W-1:0] store_q;
    logic [WORD_W-1:0] load_q;
    logic [WORD_W-3:0] cmp_addr;
    logic              req, capture, acc_done, sc_fail;
    logic              link_match, snoop_hit, sc_ok, link_set, link_clear;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{dmemaddr[1:0], snoopaddr[1:0]};

    assign req      = dmemREN || dmemWEN;
    assign req_kind = decode_kind(dmemREN, dmemWEN, datomic);

    // In IDLE the link is tested against the incoming request; afterwards
    // against the captured address so a plain write can kill its own link.
    assign cmp_addr = (state == IDLE) ? dmemaddr[WORD_W-1:2] : word_q;
    assign sc_ok    = link_match && !snoop_hit;

    assign link_set   = acc_done && (kind_q == LL);
    assign link_clear = sc_fail
                     || (acc_done && (kind_q == SC))
                     || (acc_done && (kind_q == WR) && link_match);

    atomic_link_reg #(
        .AW(WORD_W - 2)
    ) u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (link_set),
        .set_addr   (word_q),
        .clear      (link_clear),
        .halt       (halt),
        .snoop      (snoopvalid),
        .snoop_addr (snoopaddr[WORD_W-1:2]),
        .cmp_addr   (cmp_addr),
        .match      (link_match),
        .snoop_hit  (snoop_hit)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        acc_done  = 1'b0;
        sc_fail   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if ((req_kind == SC) && !sc_ok) begin
                        sc_fail   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!dwait) begin
                    acc_done  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            word_q  <= '0;
            store_q <= '0;
            kind_q  <= RD;
            load_q  <= '0;
        end else begin
            if (capture) begin
                word_q  <= dmemaddr[WORD_W-1:2];
                store_q <= dmemstore;
                kind_q  <= req_kind;
            end
            if (acc_done) begin
                case (kind_q)
                    RD, LL:  load_q <= dload;
                    SC:      load_q <= WORD_W'(SC_SUCCESS);
                    default: load_q <= load_q;
                endcase
            end
            if (sc_fail)
                load_q <= WORD_W'(SC_FAIL);
        end
    end

    assign dhit     = (state == DONE);
    assign dREN     = (state == ACCESS) && ((kind_q == RD) || (kind_q == LL));
    assign dWEN     = (state == ACCESS) && ((kind_q == WR) || (kind_q == SC));
    assign daddr    = {word_q, 2'b00};
    assign dstore   = store_q;
    assign dmemload = load_q;

endmodule

// File: tb/tb_atomic_dmem_responder.sv
// Self-checking bench: directed LL/SC scenarios plus randomized traffic
// compared against a transaction-level link/latency model.
module tb_atomic_dmem_responder;

    localparam int K_RD = 0;
    localparam int K_WR = 1;
    localparam int K_LL = 2;
    localparam int K_SC = 3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0;
    logic        halt = 1'b0;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dREN, dWEN;
    logic [31:0] daddr, dstore;
    logic [31:0] dload = '0;
    logic        dwait = 1'b0;
    logic        snoopvalid = 1'b0;
    logic [31:0] snoopaddr = '0;

    int total = 0;
    int bad   = 0;

    // reference model: reservation and last reported load value
    bit          m_valid = 1'b0;
    logic [29:0] m_addr  = '0;
    logic [31:0] m_load  = '0;

    atomic_dmem_responder #(.WORD_W(32)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .datomic    (datomic),
        .dmemaddr   (dmemaddr),
        .dmemstore  (dmemstore),
        .halt       (halt),
        .dhit       (dhit),
        .dmemload   (dmemload),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .daddr      (daddr),
        .dstore     (dstore),
        .dload      (dload),
        .dwait      (dwait),
        .snoopvalid (snoopvalid),
        .snoopaddr  (snoopaddr)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] bases [6];
        bases = '{32'h100, 32'h104, 32'h200, 32'h300, 32'h304, 32'h400};
        return bases[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
    endfunction

    task automatic idle_cycle(input bit sv, input logic [31:0] sa, input bit h);
        snoopvalid = sv;
        snoopaddr  = sa;
        halt       = h;
        if (sv && m_valid && (m_addr == sa[31:2])) m_valid = 1'b0;
        if (h) m_valid = 1'b0;
        @(negedge CLK);
        snoopvalid = 1'b0;
        halt       = 1'b0;
    endtask

    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] d,
                         input int nwait, input bit snoop_now, input logic [31:0] ld);
        bit          fail, hit, is_rd;
        int          strobes;
        logic [31:0] exp_load;
        is_rd = (k == K_RD) || (k == K_LL);
        fail  = (k == K_SC) && !(m_valid && (m_addr == a[31:2]) && !snoop_now);
        if (k == K_SC)      exp_load = fail ? 32'd0 : 32'd1;
        else if (is_rd)     exp_load = ld;
        else                exp_load = m_load;
        dmemREN    = is_rd;
        dmemWEN    = !is_rd;
        datomic    = (k == K_LL) || (k == K_SC);
        dmemaddr   = a;
        dmemstore  = d;
        dload      = ld;
        dwait      = 1'b1;
        snoopvalid = snoop_now;
        snoopaddr  = a;
        @(posedge CLK);
        #1 snoopvalid = 1'b0;
        strobes = 0;
        hit     = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (dhit) begin
                check_val("latency", c, fail ? 1 : 2 + nwait);
                check_val("strobe_cycles", strobes, fail ? 0 : nwait + 1);
                check_val("dmemload", dmemload, exp_load);
                hit = 1'b1;
                break;
            end
            check_val("dREN", {31'b0, dREN}, {31'b0, !fail && is_rd});
            check_val("dWEN", {31'b0, dWEN}, {31'b0, !fail && !is_rd});
            if (dREN || dWEN) begin
                strobes++;
                check_val("daddr", daddr, a & 32'hFFFF_FFFC);
                if (!is_rd) check_val("dstore", dstore, d);
            end
            dwait = (strobes <= nwait);
        end
        if (!hit) check_val("dhit_timeout", 32'd0, 32'd1);
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        datomic = 1'b0;
        dwait   = 1'b0;
        m_load  = exp_load;
        case (k)
            K_LL: begin m_valid = 1'b1; m_addr = a[31:2]; end
            K_WR: if (m_valid && (m_addr == a[31:2])) m_valid = 1'b0;
            K_SC: m_valid = 1'b0;
            default: ;
        endcase
    endtask

    initial begin
        #2;
        check_val("rst_dhit",     {31'b0, dhit}, 32'd0);
        check_val("rst_dREN",     {31'b0, dREN}, 32'd0);
        check_val("rst_dWEN",     {31'b0, dWEN}, 32'd0);
        check_val("rst_daddr",    daddr,    32'd0);
        check_val("rst_dstore",   dstore,   32'd0);
        check_val("rst_dmemload", dmemload, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // plain load with three wait cycles
        do_op(K_RD, 32'h104, 32'h0, 3, 1'b0, 32'hDEADBEEF);
        idle_cycle(0, 0, 0);
        // LL/SC success, then a second SC finds the link gone
        do_op(K_LL, 32'h200, 32'h0, 0, 1'b0, 32'h1234);
        idle_cycle(0, 0, 0);
        do_op(K_SC, 32'h202, 32'h55, 1, 1'b0, 32'h0);
        idle_cycle(0, 0, 0);
        do_op(K_SC, 32'h200, 32'h66, 0, 1'b0, 32'h0);
        idle_cycle(0, 0, 0);
        // snoop kills link
        do_op(K_LL, 32'h200, 32'h0, 0, 1'b0, 32'hA5A5);
        idle_cycle(1, 32'h200, 0);
        do_op(K_SC, 32'h200, 32'h77, 0, 1'b0, 32'h0);
        idle_cycle(0, 0, 0);
        // own store kills link; store to neighbour word does not
        do_op(K_LL, 32'h300, 32'h0, 0, 1'b0, 32'h1);
        idle_cycle(0, 0, 0);
        do_op(K_WR, 32'h300, 32'h9, 0, 1'b0, 32'h0);
        idle_cycle(0, 0, 0);
        do_op(K_SC, 32'h300, 32'h8, 0, 1'b0, 32'h0);
        idle_cycle(0, 0, 0);
        do_op(K_LL, 32'h300, 32'h0, 0, 1'b0, 32'h2);
        idle_cycle(0, 0, 0);
        do_op(K_WR, 32'h304, 32'h9, 2, 1'b0, 32'h0);
        idle_cycle(0, 0, 0);
        do_op(K_SC, 32'h300, 32'h8, 0, 1'b0, 32'h0);
        idle_cycle(0, 0, 0);
        // halt clears link
        do_op(K_LL, 32'h400, 32'h0, 0, 1'b0, 32'h3);
        idle_cycle(0, 0, 1);
        do_op(K_SC, 32'h400, 32'h1, 0, 1'b0, 32'h0);
        idle_cycle(0, 0, 0);
        // snoop in the same cycle as the SC match test
        do_op(K_LL, 32'h500, 32'h0, 0, 1'b0, 32'h4);
        idle_cycle(0, 0, 0);
        do_op(K_SC, 32'h500, 32'h2, 0, 1'b1, 32'h0);
        idle_cycle(0, 0, 0);

        // reset in the middle of an access
        do_op(K_LL, 32'h600, 32'h0, 0, 1'b0, 32'h5);
        idle_cycle(0, 0, 0);
        dmemREN  = 1'b1;
        dmemaddr = 32'h600;
        dwait    = 1'b1;
        @(negedge CLK);
        check_val("pre_rst_dREN", {31'b0, dREN}, 32'd1);
        nRST = 1'b0;
        #1;
        check_val("arst_dREN",     {31'b0, dREN}, 32'd0);
        check_val("arst_daddr",    daddr,    32'd0);
        check_val("arst_dmemload", dmemload, 32'd0);
        check_val("arst_dhit",     {31'b0, dhit}, 32'd0);
        dmemREN = 1'b0;
        dwait   = 1'b0;
        m_valid = 1'b0;
        m_load  = '0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        do_op(K_SC, 32'h600, 32'h3, 0, 1'b0, 32'h0);
        idle_cycle(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int k;
            k = $urandom_range(0, 3);
            do_op(k, pick_addr(), $urandom, $urandom_range(0, 3),
                  (k == K_SC) && ($urandom_range(0, 3) == 0), $urandom);
            for (int g = 0; g < int'($urandom_range(1, 2)); g++)
                idle_cycle($urandom_range(0, 3) == 0, pick_addr(),
                           $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atomic_dmem_responder.md
# atomic_dmem_responder

Data-side responder for the pipeline's memory-stage requests (dmemREN, dmemWEN, datomic). It turns each request into a single-word access on the memory-controller port, tracks the LL/SC link register, and reports completion to the pipeline through a one-cycle dhit pulse. It sits between the pipeline's memory stage and the memory controller / coherence port, and is the responding end of the request signals the control unit generates.

## Interface
Parameters:
- WORD_W, 32, data and address width.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- dmemREN  in  1  read request (LW/LL); held by the pipeline until dhit.
- dmemWEN  in  1  write request (SW/SC); held until dhit.
- datomic  in  1  qualifies the request as LL (with REN) or SC (with WEN).
- dmemaddr  in  WORD_W  byte address; bits [1:0] are ignored.
- dmemstore  in  WORD_W  store data.
- halt  in  1  processor halted; clears the link.
- dhit  out  1  one-cycle completion pulse.
- dmemload  out  WORD_W  load data, or the SC result (1 = success, 0 = fail); valid while dhit = 1.
- dREN  out  1  memory-controller read strobe.
- dWEN  out  1  memory-controller write strobe.
- daddr  out  WORD_W  memory-controller address, word-aligned ([1:0] = 0).
- dstore  out  WORD_W  memory-controller write data.
- dload  in  WORD_W  memory-controller read data.
- dwait  in  1  memory controller busy; the access completes in the first cycle with dwait = 0.
- snoopvalid  in  1  another agent is writing snoopaddr this cycle.
- snoopaddr  in  WORD_W  snooped write address.

## Operation
FSM states are IDLE, ACCESS and DONE.

- **IDLE**
  - dmemWEN together with dmemREN: the request is treated as a write.
  - Plain read, plain write, LL, or SC with a matching link: register the address, store data and kind, then go to ACCESS.
  - SC without a matching link: skip memory, go to DONE with result 0.
- **ACCESS**
  - Drive dREN or dWEN with daddr = {addr[31:2], 2'b00} and dstore.
  - Stay in ACCESS while dwait = 1.
  - When dwait = 0: latch dload on reads (1 on SC), then go to DONE.
- **DONE**
  - dhit = 1 and dmemload are valid.
  - Go to IDLE next cycle unconditionally.
  - A request still present in that IDLE cycle is treated as a new request.

Link register (link_valid, link_addr[31:2]):
- **Set:** LL completion sets link_valid = 1 and link_addr = addr[31:2].
- **SC match test:** link_valid and link_addr == dmemaddr[31:2], evaluated in IDLE.
- **Clear** link_valid on any of:
  - SC completion, whether it succeeds or fails;
  - plain write completion to link_addr;
  - snoopvalid with snoopaddr[31:2] == link_addr, in any state;
  - halt = 1.
- **Snoop on SC:** a snoop hit in the same IDLE cycle as the SC match test forces the SC to fail. A snoop hit while an SC is already in ACCESS does not cancel it, because the write is already ordered at the memory controller.
- **Snoop on LL:** a snoop hit in the same cycle as an LL completion leaves the link cleared; the snoop wins.

Reset values: state = IDLE, link_valid = 0, link_addr = 0, and dhit, dREN, dWEN, daddr, dstore, dmemload all 0. Reset mid-access abandons the transfer immediately.

## Timing
- Request seen in IDLE at cycle 0. With dwait = 0 at cycle 1, dhit is asserted at cycle 2 (latency 2). Each dwait cycle adds 1.
- A failed SC produces dhit at cycle 1 and asserts no memory strobe.
- dREN/dWEN are high only in ACCESS and are mutually exclusive. daddr/dstore are stable for the whole of ACCESS.
- dmemload is registered and is held until the next DONE.
- Snoop and halt take effect on the link at the next rising edge.

## Structure
- **cpu_types_pkg** holds:
  - word_t;
  - the dresp_state_t enum (IDLE, ACCESS, DONE);
  - the request-kind enum (RD, WR, LL, SC);
  - the constants SC_SUCCESS = 32'd1 and SC_FAIL = 32'd0.
- **atomic_link_reg** sub-module holds link_valid and link_addr:
  - inputs: set, clear, snoop, compare address;
  - output: match.
- The FSM and datapath registers live in atomic_dmem_responder.

## Test plan
- **Plain load:** LW to 0x104 with dwait high for 3 cycles and dload = 0xDEADBEEF → daddr = 0x104, dREN high for 4 cycles, dhit at cycle 5, dmemload = 0xDEADBEEF.
- **LL/SC success:** LL 0x200, then SC 0x202 with data 0x55 → dWEN to 0x200 with dstore = 0x55, dmemload = 1, link cleared afterwards.
- **SC fail by snoop:** LL 0x200, then snoopvalid with snoopaddr = 0x200, then SC 0x200 → no dWEN, dhit one cycle after the request, dmemload = 0.
- **SC fail by own store:** LL 0x300, SW 0x300, SC 0x300 → SC returns 0 with no memory write. Repeating with the SW to 0x304 → SC returns 1.
- **Reset during ACCESS:** assert nRST = 0 while dwait = 1 → all outputs 0 asynchronously, state IDLE, and a subsequent SC fails.
- **Halt:** LL 0x400, halt pulse, SC 0x400 → dmemload = 0.
